muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer, placed in the execute stage next to the single-cycle ALU.
- Accepts one M-extension op from the decoder and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Stalls the pipeline until the result is ready.
- Owns its own FSM, iteration counter and operand/accumulator registers.

Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1.

Ports:
- clk  in  1  core clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  execute stage holds an M-op (opcode 0110011, funct7=0000001)
- flush_i  in  1  kill the in-flight op (branch mispredict/trap)
- funct3_i  in  3  M-op select
- src_a_i  in  XLEN  rs1 value
- src_b_i  in  XLEN  rs2 value
- result_o  out  XLEN  registered result, valid while done_o=1
- done_o  out  1  one-cycle result strobe
- stall_o  out  1  freeze fetch/decode/execute
- busy_o  out  1  FSM not IDLE

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (any cycle, including mid-op): state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0, accumulators=0. stall_o is then valid_i & ~flush_i.
- funct3 encoding:
  - 000 MUL (low word)
  - 001 MULH (s×s)
  - 010 MULHSU (s×u)
  - 011 MULHU (u×u)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- States: IDLE, BUSY, DONE.
- IDLE, valid_i=1 and flush_i=0 (accept cycle 0):
  - Latch funct3 and operand magnitudes (abs of signed operands).
  - Latch the result-negate flag: mul = sign_a^sign_b; div = sign_a^sign_b; rem = sign_a.
  - counter=XLEN, go BUSY.
- BUSY, one iteration per cycle:
  - Multiply: 2·XLEN product, add multiplicand if multiplier LSB is set, then shift right.
  - Divide: shift remainder left by one bit, trial-subtract divisor, set quotient bit if non-negative.
  - counter decrements; at counter==1 go DONE and register the final result with sign fixup applied.
- DONE: done_o=1 for exactly one cycle, result_o valid; go IDLE unconditionally.
- Latency: done_o asserts in cycle XLEN+1 after the accept cycle (cycle 33 for XLEN=32).
- stall_o = valid_i & (state != DONE) & ~flush_i, combinational.
  - stall_o is high in the accept cycle and all BUSY cycles, low in DONE, so the pipeline advances exactly once per op.
- Back-to-back M-ops: the next op is accepted in the IDLE cycle after DONE; there is no lost or duplicate accept.
- flush_i has priority in every state:
  - Next state is IDLE, with no done_o and result_o unchanged.
  - A flush in the DONE cycle still suppresses done_o.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - DIV*: quotient.
  - REM*: remainder.
- Divide special cases (per RISC-V spec, results fixed at capture):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (src_a = MIN, src_b = -1): quotient = MIN, remainder = 0.
  - Without the optional feature these still take the full XLEN+1 latency.
- valid_i falling while BUSY without flush_i is illegal; the block treats it as don't-care and completes anyway.

Optional Feature:
- MULDIV_FAST_PATH_EN defined:
  - Divide-by-zero, signed overflow, and multiply with either operand 0 go IDLE→DONE directly.
  - done_o asserts in cycle 1 after accept; stall lasts 1 cycle.
- Undefined: every op takes XLEN+1 cycles with identical results.
- The result value must match in both builds.

Decomposition:
- Add `MD_MUL … `MD_REMU funct3 constants to the shared include, alongside the ALU control and opcode defines.
- Add the state encoding (2-bit) to the same shared include.
- One sub-module, muldiv_dp: accumulator/remainder registers, shift/add/subtract step and sign fixup.
- muldiv_seq keeps the FSM, counter, handshake and special-case detection.

Test Plan:
- MUL 7×(-3) → result 0xFFFFFFEB; done_o at cycle 33; stall_o high cycles 0–32, low at 33.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU -1×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM of the same → 0. With MULDIV_FAST_PATH_EN, done_o at cycle 1.
- flush_i pulsed at BUSY cycle 10 → IDLE next cycle, no done_o; the following MUL 3×4 returns 12 after normal latency.
- rst_n low at BUSY cycle 5 → all outputs 0 immediately. Two back-to-back DIVU ops → two done_o pulses 34 cycles apart, each with the correct result.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// M-op funct3 encodings, the 2-bit FSM state encoding and operand-sign helpers.
package muldiv_seq_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [2:0] funct3);
        return funct3[2] ? ~funct3[0] : (funct3 != MD_MULHU);
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic is_signed_b(input logic [2:0] funct3);
        return funct3[2] ? ~funct3[0] : ~funct3[1];
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Datapath of the multiply/divide sequencer: operand magnitude registers,
// shared hi/lo accumulator, one radix-2 shift-add or restoring-divide step
// per cycle, and sign fixup into the registered result.
module muldiv_dp
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            step_i,
    input  logic            capture_i,
    input  logic            force_i,
    input  logic [XLEN-1:0] force_val_i,
    output logic [XLEN-1:0] result_o
);

    logic [2:0]      op_q,     op_d;
    logic            neg_q,    neg_d;
    logic [XLEN-1:0] b_q,      b_d;
    logic [XLEN-1:0] hi_q,     hi_d;
    logic [XLEN-1:0] lo_q,     lo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ok;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // Operand conditioning, one iteration step and final result selection.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sign_a = is_signed_a(funct3_i) & src_a_i[XLEN-1];
        sign_b = is_signed_b(funct3_i) & src_b_i[XLEN-1];
        mag_a  = sign_a ? -src_a_i : src_a_i;
        mag_b  = sign_b ? -src_b_i : src_b_i;

        // Multiply: lo holds the multiplier, hi the running upper product.
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

        // Divide: hi holds the partial remainder, lo the dividend/quotient.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = ~div_diff[XLEN];

        if (op_q[2]) begin
            step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi : step_hi;

        op_d     = op_q;
        neg_d    = neg_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        if (load_i) begin
            op_d  = funct3_i;
            // Remainder takes the dividend sign; products and quotients the xor.
            neg_d = (funct3_i[2] & funct3_i[1]) ? sign_a : (sign_a ^ sign_b);
            b_d   = mag_b;
            hi_d  = '0;
            lo_d  = mag_a;
        end else if (step_i) begin
            hi_d = step_hi;
            lo_d = step_lo;
        end

        if (force_i) begin
            result_d = force_val_i;
        end else if (capture_i) begin
            unique case (op_q)
                MD_MUL:                        result_d = prod_fix[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU:  result_d = prod_fix[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:               result_d = quo_fix;
                default:                       result_d = rem_fix;
            endcase
        end
    end

    // Datapath registers, all cleared by reset.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: FSM, iteration counter,
// pipeline handshake and divide special-case detection around muldiv_dp.
// Optional macro MULDIV_FAST_PATH_EN: divide-by-zero, signed divide
// overflow and multiply by zero complete one cycle after accept.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            stall_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            done_q,     done_d;
    logic            spec_q,     spec_d;
    logic [XLEN-1:0] spec_val_q, spec_val_d;

    logic            div_zero, div_ovf, spec_hit;
    logic [XLEN-1:0] spec_val;
    logic            load, step, capture, force_res;
    logic [XLEN-1:0] force_val;
`ifdef MULDIV_FAST_PATH_EN
    logic            mul_zero;
`endif

    // Special-case detection on the incoming op and result values fixed at capture.
    always_comb begin
        div_zero = funct3_i[2] & (src_b_i == '0);
        div_ovf  = funct3_i[2] & ~funct3_i[0] & (src_a_i == MIN_VAL) & (&src_b_i);
        spec_hit = div_zero | div_ovf;
        spec_val = '0;
        if (div_zero) begin
            spec_val = funct3_i[1] ? src_a_i : '1;
        end else if (div_ovf) begin
            spec_val = funct3_i[1] ? '0 : MIN_VAL;
        end
`ifdef MULDIV_FAST_PATH_EN
        mul_zero = ~funct3_i[2] & ((src_a_i == '0) | (src_b_i == '0));
`endif
    end

    // Next-state, counter and datapath control; flush wins in every state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        force_res  = 1'b0;
        force_val  = spec_val_q;

        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        load       = 1'b1;
                        spec_d     = spec_hit;
                        spec_val_d = spec_val;
`ifdef MULDIV_FAST_PATH_EN
                        if (spec_hit | mul_zero) begin
                            force_res = 1'b1;
                            force_val = spec_val;
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = CW'(XLEN);
                        end
`else
                        state_d = ST_BUSY;
                        cnt_d   = CW'(XLEN);
`endif
                    end
                end
                ST_BUSY: begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        force_res = spec_q;
                        capture   = ~spec_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, counter and registered done strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
        end
    end

    muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .funct3_i    (funct3_i),
        .src_a_i     (src_a_i),
        .src_b_i     (src_b_i),
        .step_i      (step),
        .capture_i   (capture),
        .force_i     (force_res),
        .force_val_i (force_val),
        .result_o    (result_o)
    );

    assign done_o  = done_q & ~flush_i;
    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = valid_i & (state_q != ST_DONE) & ~flush_i;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed, table-driven bench for muldiv_seq plus hand-written sequences for
// flush, reset mid-op, flush in DONE and back-to-back ops.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            valid_i;
    logic            flush_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] src_a_i;
    logic [XLEN-1:0] src_b_i;
    logic [XLEN-1:0] result_o;
    logic            done_o;
    logic            stall_o;
    logic            busy_o;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .result_o (result_o),
        .done_o   (done_o),
        .stall_o  (stall_o),
        .busy_o   (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op with valid held until done; returns result, latency in
    // cycles after accept (-1 on timeout) and count of wrong stall samples.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stall_bad);
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = f; src_a_i = a; src_b_i = b;
        lat = -1; stall_bad = 0; res = 'x;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_o) begin
                lat = k;
                res = result_o;
                if (stall_o) stall_bad++;
                break;
            end else if (!stall_o) begin
                stall_bad++;
            end
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] res, prev;
        int lat, sbad, exp_lat, pulses, first_cyc, second_cyc;
        logic [31:0] r1, r2;
        bit seen_done;

        vecs[0]  = '{"mul_7x-3",      MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"mulh_min2",     MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        vecs[2]  = '{"mulhu_max2",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{"mulhsu_-1x2",   MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{"mulhsu_minxu",  MD_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[5]  = '{"mulh_-5x3",     MD_MULH,   32'hFFFFFFFB, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{"div_-7/2",      MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{"rem_-7/2",      MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{"divu_100/7",    MD_DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
        vecs[9]  = '{"remu_100/7",    MD_REMU,   32'd100,      32'd7,        32'd2,        1'b0};
        vecs[10] = '{"div_5/0",       MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[11] = '{"rem_5/0",       MD_REM,    32'd5,        32'd0,        32'd5,        1'b1};
        vecs[12] = '{"div_ovf",       MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[13] = '{"rem_ovf",       MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[14] = '{"div_-9/0",      MD_DIV,    32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[15] = '{"remu_big/0",    MD_REMU,   32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 1'b1};
        vecs[16] = '{"mul_0x1234",    MD_MUL,    32'd0,        32'h1234,     32'd0,        1'b1};
        vecs[17] = '{"divu_5/0",      MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};

        rst_n = 1'b0; valid_i = 1'b1; flush_i = 1'b0;
        funct3_i = MD_MUL; src_a_i = '0; src_b_i = '0;
        #12;
        check("reset_result", result_o, 32'd0);
        check("reset_done",   {31'd0, done_o}, 32'd0);
        check("reset_busy",   {31'd0, busy_o}, 32'd0);
        check("reset_stall",  {31'd0, stall_o}, 32'd1);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, sbad);
            exp_lat = (FAST && vecs[i].special) ? 1 : 33;
            check({vecs[i].name, "_result"},  res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, exp_lat);
            check({vecs[i].name, "_stall"},   sbad, 0);
        end

        // Flush at BUSY cycle 10: no done, result unchanged, then MUL 3x4.
        prev = result_o;
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = MD_MUL; src_a_i = 32'd5; src_b_i = 32'd6;
        for (int k = 0; k < 10; k++) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        check("flush_stall_low", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_idle", {31'd0, busy_o}, 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("flush_no_done", {31'd0, seen_done}, 32'd0);
        check("flush_result_kept", result_o, prev);
        do_op(MD_MUL, 32'd3, 32'd4, res, lat, sbad);
        check("post_flush_mul", res, 32'd12);
        check("post_flush_latency", lat, 33);

        // Flush in the DONE cycle suppresses done_o.
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = MD_DIVU; src_a_i = 32'd50; src_b_i = 32'd5;
        for (int k = 0; k < 33; k++) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        check("flush_done_strobe", {31'd0, done_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        check("flush_done_idle", {31'd0, busy_o | done_o}, 32'd0);

        // Reset at BUSY cycle 5 clears every output at once.
        check("pre_reset_result_nonzero", {31'd0, result_o != 32'd0}, 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = MD_DIVU; src_a_i = 32'd1000; src_b_i = 32'd3;
        for (int k = 0; k < 5; k++) @(posedge clk);
        #1;
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        check("midop_reset_result", result_o, 32'd0);
        check("midop_reset_flags", {29'd0, done_o, busy_o, stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back DIVU ops with valid held continuously.
        @(posedge clk); #1;
        valid_i = 1'b1; funct3_i = MD_DIVU; src_a_i = 32'd100; src_b_i = 32'd7;
        pulses = 0; first_cyc = -1; second_cyc = -1; r1 = '0; r2 = '0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = k; r1 = result_o;
                    @(posedge clk); #1;
                    src_a_i = 32'd1000; src_b_i = 32'd10;
                end else if (pulses == 2) begin
                    second_cyc = k; r2 = result_o;
                    @(posedge clk); #1;
                    valid_i = 1'b0;
                end
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_first_result", r1, 32'd14);
        check("b2b_second_result", r2, 32'd100);
        check("b2b_first_cycle", first_cyc, 33);
        check("b2b_gap", second_cyc - first_cyc, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
